// File: rtl/bnn_core_param_if.sv
// Handshake and data bundle for bnn_core_param: inference stream, result
// fields and the chunked weight/threshold loader.
interface bnn_core_param_if #(
  parameter int N_IN  = 8,
  parameter int N_HID = 8,
  parameter int N_OUT = 4,
  parameter int LD_W  = 4
);
  localparam int TH_W  = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int CLS_W = $clog2(N_OUT);

  logic              in_valid;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic [N_OUT-1:0]  out_bits;
  logic [CLS_W-1:0]  out_class;
  logic [TH_W-1:0]   out_score;
  logic              ld_start;
  logic              ld_valid;
  logic [LD_W-1:0]   ld_data;
  logic              ld_ready;
  logic              ld_done;

  modport master (
    output in_valid, in_data, ld_start, ld_valid, ld_data,
    input  out_valid, out_bits, out_class, out_score, ld_ready, ld_done
  );

  modport slave (
    input  in_valid, in_data, ld_start, ld_valid, ld_data,
    output out_valid, out_bits, out_class, out_score, ld_ready, ld_done
  );
endinterface

// File: rtl/bnn_core_param.sv
// Two-layer binary neural network core (XNOR-popcount neurons with
// per-neuron thresholds), double-buffered chunk loader with atomic commit,
// two-stage valid-tagged pipeline and argmax over the output layer.
//
// Loader states:
//   state  | meaning
//   S_IDLE | no load in progress, ld_ready low, ld_valid ignored
//   S_LOAD | accepting chunks into the shadow image, ld_ready high
module bnn_core_param #(
  parameter int N_IN  = 8,
  parameter int N_HID = 8,
  parameter int N_OUT = 4,
  parameter int LD_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  bnn_core_param_if.slave    bus
);
  localparam int TH_W     = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int CLS_W    = $clog2(N_OUT);
  // Image layout offsets, LSB-first stream order
  localparam int HT_OFF   = N_HID * N_IN;
  localparam int OW_OFF   = HT_OFF + N_HID * TH_W;
  localparam int OT_OFF   = OW_OFF + N_OUT * N_HID;
  localparam int IMG_BITS = OT_OFF + N_OUT * TH_W;
  localparam int N_CHUNK  = (IMG_BITS + LD_W - 1) / LD_W;
  localparam int SH_BITS  = N_CHUNK * LD_W;
  localparam int PTR_W    = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CHUNK - 1);

  // Power-on active set: zero weights, thresholds at half fan-in
  function automatic logic [IMG_BITS-1:0] default_image();
    logic [IMG_BITS-1:0] img;
    img = '0;
    for (int h = 0; h < N_HID; h++)
      img[HT_OFF + h*TH_W +: TH_W] = TH_W'(N_IN / 2);
    for (int o = 0; o < N_OUT; o++)
      img[OT_OFF + o*TH_W +: TH_W] = TH_W'(N_HID / 2);
    return img;
  endfunction

  localparam logic [IMG_BITS-1:0] DEF_IMG = default_image();

  function automatic logic [TH_W-1:0] pop_xnor_hid(input logic [N_IN-1:0] x,
                                                   input logic [N_IN-1:0] w);
    logic [TH_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_IN; i++)
      cnt = cnt + TH_W'(x[i] ~^ w[i]);
    return cnt;
  endfunction

  function automatic logic [TH_W-1:0] pop_xnor_out(input logic [N_HID-1:0] x,
                                                   input logic [N_HID-1:0] w);
    logic [TH_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_HID; i++)
      cnt = cnt + TH_W'(x[i] ~^ w[i]);
    return cnt;
  endfunction

  typedef enum logic {S_IDLE, S_LOAD} ld_state_t;

  ld_state_t            state, state_nxt;
  logic [PTR_W-1:0]     ptr;
  logic [SH_BITS-1:0]   shadow_img;
  logic [SH_BITS-1:0]   shadow_wr;
  logic [IMG_BITS-1:0]  active_img;
  logic                 ld_ready_c;
  logic                 accept;
  logic                 commit;
  logic                 ptr_clr;
  logic                 ld_done_q;

  logic [N_HID-1:0]     hid_act;
  logic [N_HID-1:0]     hid_q;
  logic                 v1_q;
  logic [N_OUT-1:0]     out_act;
  logic [TH_W-1:0]      pop_o;
  logic [TH_W-1:0]      best_pop;
  logic [CLS_W-1:0]     best_idx;
  logic                 out_valid_q;
  logic [N_OUT-1:0]     out_bits_q;
  logic [CLS_W-1:0]     out_class_q;
  logic [TH_W-1:0]      out_score_q;

  // Loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Loader next state and handshake decode; restart beats a same-cycle chunk
  always_comb begin
    state_nxt  = state;
    ld_ready_c = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    ptr_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ld_start) begin
          state_nxt = S_LOAD;
          ptr_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        ld_ready_c = 1'b1;
        if (bus.ld_start) begin
          ptr_clr = 1'b1;
        end else if (bus.ld_valid) begin
          accept = 1'b1;
          if (ptr == LAST_PTR) begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow image with the offered chunk merged in at the current pointer
  always_comb begin
    shadow_wr = shadow_img;
    for (int c = 0; c < N_CHUNK; c++)
      if (ptr == PTR_W'(c)) shadow_wr[c*LD_W +: LD_W] = bus.ld_data;
  end

  // Pointer, shadow and active sets; commit copies the merged image so the
  // final chunk lands in the active set at the same edge it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      shadow_img <= '0;
      active_img <= DEF_IMG;
      ld_done_q  <= 1'b0;
    end else begin
      ld_done_q <= commit;
      if (ptr_clr || commit) ptr <= '0;
      else if (accept)       ptr <= ptr + 1'b1;
      if (accept) shadow_img <= shadow_wr;
      if (commit) active_img <= shadow_wr[IMG_BITS-1:0];
    end
  end

  // Hidden layer activations from the active set
  always_comb begin
    hid_act = '0;
    for (int h = 0; h < N_HID; h++)
      hid_act[h] = pop_xnor_hid(bus.in_data, active_img[h*N_IN +: N_IN])
                   >= active_img[HT_OFF + h*TH_W +: TH_W];
  end

  // Stage 1: register hidden activations and the sample valid tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      hid_q <= '0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) hid_q <= hid_act;
    end
  end

  // Output layer activations and argmax; strict compare keeps lowest index on ties
  always_comb begin
    out_act  = '0;
    pop_o    = '0;
    best_pop = '0;
    best_idx = '0;
    for (int o = 0; o < N_OUT; o++) begin
      pop_o      = pop_xnor_out(hid_q, active_img[OW_OFF + o*N_HID +: N_HID]);
      out_act[o] = pop_o >= active_img[OT_OFF + o*TH_W +: TH_W];
      if (pop_o > best_pop) begin
        best_pop = pop_o;
        best_idx = CLS_W'(o);
      end
    end
  end

  // Stage 2: register results; fields hold while no sample is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_class_q <= '0;
      out_score_q <= '0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_bits_q  <= out_act;
        out_class_q <= best_idx;
        out_score_q <= best_pop;
      end
    end
  end

  assign bus.ld_ready  = ld_ready_c;
  assign bus.ld_done   = ld_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;

endmodule

// File: tb/tb_bnn_core_param.sv
// Directed bench for bnn_core_param at default parameters: hand-computed
// vectors plus a small reference model fed from the bench's own weight copy.
module tb_bnn_core_param;
  localparam int N_IN = 8, N_HID = 8, N_OUT = 4, LD_W = 4;
  localparam int IMG_BITS = 144, N_CHUNK = 36;

  typedef struct packed {
    logic [3:0] bits;
    logic [1:0] cls;
    logic [3:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_core_param_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .LD_W(LD_W)) bus();

  bnn_core_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .LD_W(LD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   d0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [IMG_BITS-1:0] img;

  logic [7:0] m_hw[8];
  logic [3:0] m_ht[8];
  logic [7:0] m_ow[4];
  logic [3:0] m_ot[4];
  logic [7:0] p_hw[8];
  logic [3:0] p_ht[8];
  logic [7:0] p_ow[4];
  logic [3:0] p_ot[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] b, input logic [1:0] c, input logic [3:0] s);
    exp_t e;
    e.bits = b; e.cls = c; e.score = s;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] x);
    exp_t e;
    logic [7:0] hid;
    int pop, best;
    e = '0; hid = '0; best = 0;
    for (int h = 0; h < 8; h++)
      hid[h] = ($countones(~(x ^ m_hw[h])) >= int'(m_ht[h]));
    for (int o = 0; o < 4; o++) begin
      pop = $countones(~(hid ^ m_ow[o]));
      e.bits[o] = (pop >= int'(m_ot[o]));
      if (pop > best) begin
        best = pop;
        e.cls = 2'(o);
      end
    end
    e.score = 4'(best);
    return e;
  endfunction

  function automatic logic [IMG_BITS-1:0] build_image();
    logic [IMG_BITS-1:0] v;
    v = '0;
    for (int h = 0; h < 8; h++) begin
      v[h*8 +: 8]      = p_hw[h];
      v[64 + h*4 +: 4] = p_ht[h];
    end
    for (int o = 0; o < 4; o++) begin
      v[96 + o*8 +: 8]  = p_ow[o];
      v[128 + o*4 +: 4] = p_ot[o];
    end
    return v;
  endfunction

  task automatic set_defaults();
    for (int h = 0; h < 8; h++) begin m_hw[h] = 8'h00; m_ht[h] = 4'd4; end
    for (int o = 0; o < 4; o++) begin m_ow[o] = 8'h00; m_ot[o] = 4'd4; end
  endtask

  task automatic commit_model();
    for (int h = 0; h < 8; h++) begin m_hw[h] = p_hw[h]; m_ht[h] = p_ht[h]; end
    for (int o = 0; o < 4; o++) begin m_ow[o] = p_ow[o]; m_ot[o] = p_ot[o]; end
  endtask

  // Result monitor: every out_valid must match the oldest outstanding sample
  always @(negedge clk) begin
    if (bus.ld_done) done_cnt++;
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("out_bits",  32'(bus.out_bits),  32'(mon_e.bits));
        check_eq("out_class", 32'(bus.out_class), 32'(mon_e.cls));
        check_eq("out_score", 32'(bus.out_score), 32'(mon_e.score));
      end
    end
  end

  task automatic sample(input logic [7:0] d, input exp_t e);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
    check_eq("latency_k1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check_eq("latency_k2", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic send_chunk(input logic [3:0] d, input bit gaps);
    int n;
    bit ok;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_data = 4'($urandom);
      end
    end
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_data = d;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (bus.ld_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.ld_valid = 1'b0;
    if (!ok) check_eq("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
  endtask

  task automatic pulse_start(input bit with_valid);
    @(negedge clk);
    bus.ld_start = 1'b1; bus.ld_valid = with_valid; bus.ld_data = 4'($urandom);
    @(posedge clk);
    #1 bus.ld_start = 1'b0; bus.ld_valid = 1'b0;
  endtask

  task automatic load_chunks(input logic [IMG_BITS-1:0] v, input int first, input int last,
                             input bit gaps);
    for (int c = first; c <= last; c++) send_chunk(v[c*4 +: 4], gaps);
  endtask

  task automatic finish_load(input logic [IMG_BITS-1:0] v);
    int base;
    base = done_cnt;
    load_chunks(v, 0, N_CHUNK - 2, 1'b1);
    check_eq("no_early_done", 32'(done_cnt - base), 32'd0);
    send_chunk(v[(N_CHUNK-1)*4 +: 4], 1'b0);
    @(negedge clk);
    check_eq("ld_done_pulse", 32'(bus.ld_done), 32'd1);
    check_eq("ld_ready_idle", 32'(bus.ld_ready), 32'd0);
    @(negedge clk);
    check_eq("ld_done_width", 32'(bus.ld_done), 32'd0);
    check_eq("ld_done_count", 32'(done_cnt - base), 32'd1);
    commit_model();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    set_defaults();
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_bits",  32'(bus.out_bits),  32'd0);
    check_eq("rst_out_class", 32'(bus.out_class), 32'd0);
    check_eq("rst_out_score", 32'(bus.out_score), 32'd0);
    check_eq("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
    check_eq("rst_ld_done",   32'(bus.ld_done),   32'd0);
    reset = 1'b0;

    // Default set
    sample(8'h0F, mk(4'b0000, 2'd0, 4'd0));
    sample(8'hFF, mk(4'b1111, 2'd0, 4'd8));

    // Full load, set A
    for (int h = 0; h < 8; h++) begin p_hw[h] = 8'hFF; p_ht[h] = 4'd8; end
    for (int o = 0; o < 4; o++) begin p_ow[o] = (o == 2) ? 8'hFF : 8'h00; p_ot[o] = 4'd8; end
    img = build_image();
    pulse_start(1'b0);
    finish_load(img);
    sample(8'hFF, mk(4'b0100, 2'd2, 4'd8));
    sample(8'h0F, mk(4'b1011, 2'd0, 4'd8));

    // Partial garbage load, restart (with a colliding chunk), then set B
    pulse_start(1'b0);
    for (int c = 0; c < 10; c++) send_chunk(4'($urandom), 1'b1);
    pulse_start(1'b1);
    for (int h = 0; h < 8; h++) begin p_hw[h] = 8'hF0; p_ht[h] = 4'd4; end
    for (int o = 0; o < 4; o++) begin p_ow[o] = (o == 1) ? 8'hFF : 8'h00; p_ot[o] = 4'd2; end
    img = build_image();
    load_chunks(img, 0, 19, 1'b1);
    check_eq("ld_ready_load", 32'(bus.ld_ready), 32'd1);
    sample(8'hFF, mk(4'b0100, 2'd2, 4'd8));
    sample(8'h3C, model(8'h3C));
    sample(8'hA5, model(8'hA5));
    d0 = done_cnt;
    load_chunks(img, 20, N_CHUNK - 2, 1'b1);
    check_eq("restart_no_early_done", 32'(done_cnt - d0), 32'd0);
    send_chunk(img[(N_CHUNK-1)*4 +: 4], 1'b0);
    @(negedge clk);
    check_eq("restart_ld_done", 32'(bus.ld_done), 32'd1);
    @(negedge clk);
    commit_model();
    sample(8'hF0, mk(4'b0010, 2'd1, 4'd8));
    sample(8'h0F, mk(4'b1101, 2'd0, 4'd8));

    // Back-to-back stream against the model
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i < 20) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        exp_q.push_back(model(bus.in_data));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (i >= 2) check_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    check_eq("b2b_tail_idle", 32'(bus.out_valid), 32'd0);
    check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a load
    pulse_start(1'b0);
    for (int c = 0; c < 20; c++) send_chunk(4'($urandom), 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    set_defaults();
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("midrst_ld_ready_idle", 32'(bus.ld_ready), 32'd0);
    sample(8'hFF, mk(4'b1111, 2'd0, 4'd8));
    sample(8'h0F, mk(4'b0000, 2'd0, 4'd0));

    repeat (3) @(negedge clk);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
